// File: rtl/inst_buffer_pkg.sv
// Shared types for the fetch-to-issue instruction buffer.
// Holds the IF/ID packet layout and the default buffer depth.
package inst_buffer_pkg;

    localparam int IBUF_DEPTH = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        predict_taken;
        logic [31:0] predict_target_pc;
    } IF_ID_PACKET;

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch/issue side bundle of the instruction buffer.
// master = fetch/issue stages, slave = the buffer itself.
interface inst_buffer_if
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = IBUF_DEPTH
);
    IF_ID_PACKET              if_packet_in;
    logic                     flush;
    logic                     is_stall;
    logic                     enq_ready;
    IF_ID_PACKET              if_id_packet_out;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output if_packet_in, flush, is_stall,
        input  enq_ready, if_id_packet_out, count
    );

    modport slave (
        input  if_packet_in, flush, is_stall,
        output enq_ready, if_id_packet_out, count
    );
endinterface

// File: rtl/inst_buffer.sv
// Purpose: FIFO decoupling fetch from issue; flush empties it. Option macro: IBUF_BYPASS_EN.
// Latency: 1 cycle enqueue-to-head (0 with IBUF_BYPASS_EN when empty).
// Backpressure: enq_ready = not full from registered count; is_stall holds the head.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = IBUF_DEPTH
) (
    input  logic          clock,
    input  logic          reset,
    inst_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    IF_ID_PACKET   entries [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count_q;

    logic full;
    logic empty;
    logic enq_fire;
    logic deq_fire;
    logic wr_en;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign enq_fire = bus.if_packet_in.valid & ~full & ~bus.flush;

`ifdef IBUF_BYPASS_EN
    logic bypass;
    // An empty buffer hands the incoming packet straight to issue; it is only
    // stored if issue cannot take it this cycle.
    assign bypass   = empty & enq_fire;
    assign wr_en    = enq_fire & ~(bypass & ~bus.is_stall);
`else
    assign wr_en    = enq_fire;
`endif

    assign deq_fire = ~empty & ~bus.is_stall & ~bus.flush;

    assign bus.enq_ready = ~full;
    assign bus.count     = count_q;

    always_comb begin
        bus.if_id_packet_out = '0;
        if (!empty) begin
            bus.if_id_packet_out = entries[head];
        end
`ifdef IBUF_BYPASS_EN
        if (bypass) begin
            bus.if_id_packet_out = bus.if_packet_in;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                tail <= tail + 1'b1;
            end
            if (deq_fire) begin
                head <= head + 1'b1;
            end
            count_q <= count_q + CW'(wr_en) - CW'(deq_fire);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else if (wr_en) begin
            entries[tail] <= bus.if_packet_in;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (count_q <= CW'(DEPTH))
                else $error("inst_buffer occupancy out of range: %0d", count_q);
        end
    end
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer with a queue-based reference model.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int DEPTH = IBUF_DEPTH;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    inst_buffer_if #(.DEPTH(DEPTH)) bus ();

    inst_buffer #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    IF_ID_PACKET q[$];
    bit seen_40 = 1'b0;
    IF_ID_PACKET idle = '0;

    function automatic IF_ID_PACKET mk(input logic [31:0] pc);
        IF_ID_PACKET p;
        p.valid             = 1'b1;
        p.inst              = 32'h0000_0013 ^ (pc << 8);
        p.pc                = pc;
        p.npc               = pc + 32'd4;
        p.predict_taken     = pc[4];
        p.predict_target_pc = pc + 32'h100;
        return p;
    endfunction

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic chk_pkt(input string name, input IF_ID_PACKET got, input IF_ID_PACKET exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, exp);
        end
    endtask

    // Apply one cycle of inputs, check outputs against the model, then clock.
    task automatic cycle(input IF_ID_PACKET pkt, input logic fl, input logic st,
                         input logic rs, input bit chk = 1'b1);
        IF_ID_PACKET exp_out;
        bit enq;
        bit deq;
        bus.if_packet_in = pkt;
        bus.flush        = fl;
        bus.is_stall     = st;
        reset            = rs;
        #1;
        if (chk) begin
            exp_out = (q.size() != 0) ? q[0] : '0;
`ifdef IBUF_BYPASS_EN
            if (q.size() == 0 && pkt.valid && !fl) exp_out = pkt;
`endif
            lit("count", 32'(bus.count), 32'(q.size()));
            lit("enq_ready", 32'(bus.enq_ready), 32'(q.size() != DEPTH));
            chk_pkt("out_pkt", bus.if_id_packet_out, exp_out);
            if (bus.if_id_packet_out.valid === 1'b1 && bus.if_id_packet_out.pc == 32'h40)
                seen_40 = 1'b1;
        end
        @(posedge clock);
        if (rs || fl) begin
            q.delete();
        end else begin
            enq = pkt.valid && (q.size() != DEPTH);
            deq = (q.size() != 0) && !st;
`ifdef IBUF_BYPASS_EN
            if (q.size() == 0 && enq && !st) enq = 1'b0;
`endif
            if (deq) void'(q.pop_front());
            if (enq) q.push_back(pkt);
        end
        @(negedge clock);
    endtask

    initial begin
        bus.if_packet_in = '0;
        bus.flush        = 1'b0;
        bus.is_stall     = 1'b0;
        reset            = 1'b1;
        @(negedge clock);
        cycle(idle, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(idle, 1'b0, 1'b0, 1'b1);

        // Reset state
        lit("rst_count", 32'(bus.count), 32'd0);
        lit("rst_enq_ready", 32'(bus.enq_ready), 32'd1);
        chk_pkt("rst_out", bus.if_id_packet_out, '0);

        // Test 1: three stalled enqueues, then drain in order
        cycle(mk(32'h0), 1'b0, 1'b1, 1'b0);
        cycle(mk(32'h4), 1'b0, 1'b1, 1'b0);
        cycle(mk(32'h8), 1'b0, 1'b1, 1'b0);
        lit("t1_count", 32'(bus.count), 32'd3);
        lit("t1_head_pc", bus.if_id_packet_out.pc, 32'h0);
        cycle(idle, 1'b0, 1'b1, 1'b0);
        lit("t1_held_pc", bus.if_id_packet_out.pc, 32'h0);
        cycle(idle, 1'b0, 1'b0, 1'b0);
        lit("t1_pc4", bus.if_id_packet_out.pc, 32'h4);
        cycle(idle, 1'b0, 1'b0, 1'b0);
        lit("t1_pc8", bus.if_id_packet_out.pc, 32'h8);
        cycle(idle, 1'b0, 1'b0, 1'b0);
        lit("t1_empty_valid", 32'(bus.if_id_packet_out.valid), 32'd0);

        // Test 2: fill to DEPTH, overflow attempt, one dequeue reopens
        for (int i = 0; i < DEPTH; i++) cycle(mk(32'h100 + 32'(4 * i)), 1'b0, 1'b1, 1'b0);
        lit("t2_full_ready", 32'(bus.enq_ready), 32'd0);
        cycle(mk(32'h10), 1'b0, 1'b1, 1'b0);
        lit("t2_full_count", 32'(bus.count), 32'(DEPTH));
        cycle(mk(32'h10), 1'b0, 1'b0, 1'b0);
        lit("t2_reopen_ready", 32'(bus.enq_ready), 32'd1);
        lit("t2_reopen_count", 32'(bus.count), 32'(DEPTH - 1));
        for (int i = 0; i < DEPTH; i++) cycle(idle, 1'b0, 1'b0, 1'b0);

        // Test 3: steady enq+deq at count 2 across pointer wrap
        cycle(mk(32'h200), 1'b0, 1'b1, 1'b0);
        cycle(mk(32'h204), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(mk(32'h208 + 32'(4 * i)), 1'b0, 1'b0, 1'b0);
            lit("t3_count", 32'(bus.count), 32'd2);
        end
        lit("t3_head_pc", bus.if_id_packet_out.pc, 32'h218);
        cycle(idle, 1'b0, 1'b0, 1'b0);
        cycle(idle, 1'b0, 1'b0, 1'b0);

        // Test 4: flush with concurrent enqueue
        for (int i = 0; i < 3; i++) cycle(mk(32'h300 + 32'(4 * i)), 1'b0, 1'b1, 1'b0);
        cycle(mk(32'h40), 1'b1, 1'b0, 1'b0);
        lit("t4_count", 32'(bus.count), 32'd0);
        lit("t4_valid", 32'(bus.if_id_packet_out.valid), 32'd0);
        cycle(idle, 1'b0, 1'b0, 1'b0);
        cycle(idle, 1'b0, 1'b0, 1'b0);
        lit("t4_no_0x40", 32'(seen_40), 32'd0);

        // Test 5: reset mid-operation
        cycle(mk(32'h500), 1'b0, 1'b1, 1'b0);
        cycle(mk(32'h504), 1'b0, 1'b1, 1'b0);
        lit("t5_pre_count", 32'(bus.count), 32'd2);
        cycle(idle, 1'b0, 1'b1, 1'b1);
        lit("t5_count", 32'(bus.count), 32'd0);
        lit("t5_enq_ready", 32'(bus.enq_ready), 32'd1);
        chk_pkt("t5_out", bus.if_id_packet_out, '0);
        cycle(idle, 1'b0, 1'b0, 1'b0);

        // Test 6: fetch-to-issue latency from empty
`ifdef IBUF_BYPASS_EN
        bus.if_packet_in = mk(32'h80);
        bus.is_stall     = 1'b0;
        #1;
        lit("t6_bypass_pc", bus.if_id_packet_out.pc, 32'h80);
        cycle(mk(32'h80), 1'b0, 1'b0, 1'b0);
        lit("t6_bypass_count", 32'(bus.count), 32'd0);
`else
        cycle(mk(32'h80), 1'b0, 1'b0, 1'b0);
        lit("t6_count", 32'(bus.count), 32'd1);
        lit("t6_pc", bus.if_id_packet_out.pc, 32'h80);
        cycle(idle, 1'b0, 1'b0, 1'b0);
`endif
        cycle(idle, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
